// File: rtl/mem_access_stage.sv
// MIPS memory-access stage: byte/half/word loads and stores over a req/ack port; other ops pass through.
// Latency: pass-through and addr_error take 1 cycle; memory ops complete 1 cycle after mem_ack, or raise bus_error after TIMEOUT_CYCLES.
// Backpressure: stall is combinational while an access is being issued or is outstanding, and drops in the mem_ack cycle.
module mem_access_stage #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int ADDR_W         = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              valid_in,
  input  logic [31:0]       alu_result,
  input  logic [31:0]       store_data,
  input  logic [31:0]       insn,
  output logic              stall,
  output logic              valid_out,
  output logic [31:0]       data_out,
  output logic              addr_error,
  output logic              bus_error,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  // Index 0 is byte offset 0 (data bits 31:24), matching the big-endian bit numbering of the bus.
  output logic [0:3]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  typedef enum logic {IDLE, WAIT} state_t;

  state_t        state, state_nxt;
  logic [TW-1:0] timer;
  logic [1:0]    ld_size;
  logic          ld_signed;
  logic [1:0]    ld_off;

  logic          is_load, is_store, op_signed, aligned, accept_mem, expire;
  logic [1:0]    op_size;
  logic [7:0]    ld_byte;
  logic [15:0]   ld_half;
  logic [31:0]   load_val;
  logic          unused_insn;

  // Only the opcode field of the instruction word is relevant here.
  assign unused_insn = ^insn[25:0];

  // Decode the opcode (insn[31:26]) and check address alignment for its access size.
  always_comb begin
    is_load   = 1'b0;
    is_store  = 1'b0;
    op_signed = 1'b0;
    op_size   = SZ_W;
    case (insn[31:26])
      6'b100000: begin is_load  = 1'b1; op_size = SZ_B; op_signed = 1'b1; end
      6'b100001: begin is_load  = 1'b1; op_size = SZ_H; op_signed = 1'b1; end
      6'b100011: begin is_load  = 1'b1; op_size = SZ_W; end
      6'b100100: begin is_load  = 1'b1; op_size = SZ_B; end
      6'b100101: begin is_load  = 1'b1; op_size = SZ_H; end
      6'b101000: begin is_store = 1'b1; op_size = SZ_B; end
      6'b101001: begin is_store = 1'b1; op_size = SZ_H; end
      6'b101011: begin is_store = 1'b1; op_size = SZ_W; end
      default:   ;
    endcase
    case (op_size)
      SZ_W:    aligned = (alu_result[1:0] == 2'b00);
      SZ_H:    aligned = ~alu_result[0];
      default: aligned = 1'b1;
    endcase
    accept_mem = valid_in && (is_load || is_store) && aligned;
    expire     = (timer == TW'(TIMEOUT_CYCLES - 1));
  end

  // Pick the addressed lane from the read word (byte 0 is the most significant) and extend it.
  always_comb begin
    case (ld_off)
      2'd0:    ld_byte = mem_rdata[31:24];
      2'd1:    ld_byte = mem_rdata[23:16];
      2'd2:    ld_byte = mem_rdata[15:8];
      default: ld_byte = mem_rdata[7:0];
    endcase
    ld_half = ld_off[1] ? mem_rdata[15:0] : mem_rdata[31:16];
    case (ld_size)
      SZ_B:    load_val = {{24{ld_signed & ld_byte[7]}}, ld_byte};
      SZ_H:    load_val = {{16{ld_signed & ld_half[15]}}, ld_half};
      default: load_val = mem_rdata;
    endcase
  end

  // Next state and stall: stall covers the issue cycle and every WAIT cycle except the ack cycle.
  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    case (state)
      IDLE: begin
        if (accept_mem) begin
          stall     = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        stall = ~mem_ack;
        if (mem_ack || expire) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Datapath: issue requests with lane-steered enables/data, complete on ack, abort on timeout.
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_out  <= 1'b0;
      data_out   <= '0;
      addr_error <= 1'b0;
      bus_error  <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_be     <= '0;
      mem_wdata  <= '0;
      timer      <= '0;
      ld_size    <= SZ_W;
      ld_signed  <= 1'b0;
      ld_off     <= 2'd0;
    end else begin
      valid_out  <= 1'b0;
      addr_error <= 1'b0;
      bus_error  <= 1'b0;
      case (state)
        IDLE: begin
          if (valid_in && !(is_load || is_store)) begin
            valid_out <= 1'b1;
            data_out  <= alu_result;
          end else if (valid_in && !aligned) begin
            addr_error <= 1'b1;
          end else if (accept_mem) begin
            mem_req   <= 1'b1;
            mem_we    <= is_store;
            mem_addr  <= ADDR_W'({alu_result[31:2], 2'b00});
            ld_size   <= op_size;
            ld_signed <= op_signed;
            ld_off    <= alu_result[1:0];
            timer     <= '0;
            if (is_load) begin
              mem_be    <= 4'b1111;
              mem_wdata <= '0;
            end else begin
              case (op_size)
                SZ_B: begin
                  mem_be    <= 4'b1000 >> alu_result[1:0];
                  mem_wdata <= {4{store_data[7:0]}};
                end
                SZ_H: begin
                  mem_be    <= alu_result[1] ? 4'b0011 : 4'b1100;
                  mem_wdata <= {2{store_data[15:0]}};
                end
                default: begin
                  mem_be    <= 4'b1111;
                  mem_wdata <= store_data;
                end
              endcase
            end
          end
        end
        WAIT: begin
          if (mem_ack) begin
            mem_req   <= 1'b0;
            valid_out <= 1'b1;
            timer     <= '0;
            if (!mem_we) data_out <= load_val;
          end else if (expire) begin
            mem_req   <= 1'b0;
            bus_error <= 1'b1;
            timer     <= '0;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage with hand-computed expected values.
// Inputs change and outputs are sampled on the falling clock edge.
// Memory acks are driven by the bench; every wait loop is bounded.
module tb_mem_access_stage;

  localparam logic [5:0] OP_ADD = 6'b000000;
  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SW  = 6'b101011;

  logic        clock = 1'b0;
  logic        reset;
  logic        valid_in;
  logic [31:0] alu_result, store_data, insn;
  logic        stall, valid_out, addr_error, bus_error;
  logic [31:0] data_out;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr;
  logic [0:3]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  mem_access_stage #(.TIMEOUT_CYCLES(4), .ADDR_W(32)) dut (
    .clock(clock), .reset(reset), .valid_in(valid_in), .alu_result(alu_result),
    .store_data(store_data), .insn(insn), .stall(stall), .valid_out(valid_out),
    .data_out(data_out), .addr_error(addr_error), .bus_error(bus_error),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present one instruction for a single cycle; returns at the falling edge after it was clocked in.
  task automatic issue(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] sd,
                       input logic exp_stall, input string tag);
    valid_in   = 1'b1;
    insn       = {op, 26'h0};
    alu_result = addr;
    store_data = sd;
    #1 check({tag, "_issue_stall"}, 32'(stall), 32'(exp_stall));
    @(negedge clock);
    valid_in = 1'b0;
    insn     = 32'h0;
  endtask

  // Full memory transaction: issue, check request fields, hold for wait_n cycles, ack, check completion.
  task automatic mem_txn(input string tag, input logic [5:0] op, input logic [31:0] addr,
                         input logic [31:0] sd, input logic [31:0] rdata, input int wait_n,
                         input logic exp_we, input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                         input logic [31:0] exp_dout);
    issue(op, addr, sd, 1'b1, tag);
    check({tag, "_req"},   32'(mem_req), 32'd1);
    check({tag, "_we"},    32'(mem_we), 32'(exp_we));
    check({tag, "_addr"},  mem_addr, addr & 32'hFFFF_FFFC);
    check({tag, "_be"},    32'(mem_be), 32'(exp_be));
    check({tag, "_wdata"}, mem_wdata, exp_wdata);
    for (int i = 0; i < wait_n; i++) begin
      check({tag, "_wait_stall"}, 32'(stall), 32'd1);
      @(negedge clock);
      check({tag, "_hold_req"},  32'(mem_req), 32'd1);
      check({tag, "_hold_addr"}, mem_addr, addr & 32'hFFFF_FFFC);
    end
    mem_ack   = 1'b1;
    mem_rdata = rdata;
    #1 check({tag, "_ack_stall"}, 32'(stall), 32'd0);
    @(negedge clock);
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    check({tag, "_valid"},   32'(valid_out), 32'd1);
    check({tag, "_req_off"}, 32'(mem_req), 32'd0);
    check({tag, "_dout"},    data_out, exp_dout);
    @(negedge clock);
    check({tag, "_valid_pulse"}, 32'(valid_out), 32'd0);
  endtask

  initial begin
    int n;
    reset      = 1'b1;
    valid_in   = 1'b0;
    alu_result = 32'h0;
    store_data = 32'h0;
    insn       = 32'h0;
    mem_ack    = 1'b0;
    mem_rdata  = 32'h0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;

    check("rst_stall", 32'(stall), 32'd0);
    check("rst_valid", 32'(valid_out), 32'd0);
    check("rst_req",   32'(mem_req), 32'd0);
    check("rst_dout",  data_out, 32'h0);
    check("rst_addr",  mem_addr, 32'h0);

    // Pass-through ADD
    issue(OP_ADD, 32'h0000_0007, 32'h0, 1'b0, "add");
    check("add_valid", 32'(valid_out), 32'd1);
    check("add_dout",  data_out, 32'h0000_0007);
    check("add_stall", 32'(stall), 32'd0);
    @(negedge clock);
    check("add_valid_pulse", 32'(valid_out), 32'd0);

    // Loads with sign/zero extension
    mem_txn("lb",  OP_LB,  32'h0000_0101, 32'h0, 32'h12F4_5678, 2, 1'b0, 4'b1111, 32'h0, 32'hFFFF_FFF4);
    mem_txn("lbu", OP_LBU, 32'h0000_0101, 32'h0, 32'h12F4_5678, 1, 1'b0, 4'b1111, 32'h0, 32'h0000_00F4);
    mem_txn("lh",  OP_LH,  32'h0000_0102, 32'h0, 32'h1234_8001, 0, 1'b0, 4'b1111, 32'h0, 32'hFFFF_8001);
    mem_txn("lw",  OP_LW,  32'h0000_0104, 32'h0, 32'hCAFE_0123, 1, 1'b0, 4'b1111, 32'h0, 32'hCAFE_0123);

    // Stores: data_out keeps the previous load result
    mem_txn("sh", OP_SH, 32'h0000_0202, 32'hAAAA_BEEF, 32'h0, 2, 1'b1, 4'b0011, 32'hBEEF_BEEF, 32'hCAFE_0123);
    mem_txn("sb", OP_SB, 32'h0000_0103, 32'h0000_00A5, 32'h0, 0, 1'b1, 4'b0001, 32'hA5A5_A5A5, 32'hCAFE_0123);

    // Misaligned word load
    issue(OP_LW, 32'h0000_0006, 32'h0, 1'b0, "mis");
    check("mis_addr_error", 32'(addr_error), 32'd1);
    check("mis_req",        32'(mem_req), 32'd0);
    check("mis_valid",      32'(valid_out), 32'd0);
    @(negedge clock);
    check("mis_pulse", 32'(addr_error), 32'd0);
    check("mis_req2",  32'(mem_req), 32'd0);

    // Store with no ack: timeout after 4 WAIT cycles
    issue(OP_SW, 32'h0000_0300, 32'h1111_2222, 1'b1, "to");
    n = 0;
    for (int i = 0; i < 10 && mem_req; i++) begin
      n++;
      @(negedge clock);
    end
    check("to_req_cycles", 32'(n), 32'd4);
    check("to_bus_error",  32'(bus_error), 32'd1);
    check("to_valid",      32'(valid_out), 32'd0);
    check("to_stall",      32'(stall), 32'd0);
    @(negedge clock);
    check("to_pulse", 32'(bus_error), 32'd0);
    issue(OP_ADD, 32'h0000_0055, 32'h0, 1'b0, "post_to");
    check("post_to_valid", 32'(valid_out), 32'd1);
    check("post_to_dout",  data_out, 32'h0000_0055);
    @(negedge clock);

    // Reset during WAIT, late ack ignored
    issue(OP_LW, 32'h0000_0400, 32'h0, 1'b1, "rw");
    check("rw_req", 32'(mem_req), 32'd1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("rw_req_dropped", 32'(mem_req), 32'd0);
    mem_ack   = 1'b1;
    mem_rdata = 32'hDEAD_BEEF;
    #1 check("rw_ack_stall", 32'(stall), 32'd0);
    @(negedge clock);
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    check("rw_valid", 32'(valid_out), 32'd0);
    check("rw_req2",  32'(mem_req), 32'd0);
    check("rw_dout",  data_out, 32'h0);
    check("rw_addr",  mem_addr, 32'h0);
    check("rw_be",    32'(mem_be), 32'h0);
    check("rw_wdata", mem_wdata, 32'h0);
    check("rw_stall", 32'(stall), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
